mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and burst sequencer that shares one pipelined main-memory port between the instruction-side refill path (port I) and the data-cache refill/write-back path (port D). Sits between the two cache controllers and the single backing memory. Each grant runs a fixed-length block burst, read or write. Round-robin priority resolves simultaneous requests.

## Interface
- ADDR_W, 9, word address width (matches 9-bit memory word index)
- DATA_W, 32, data width
- BLOCK_WORDS, 4, words per burst; power of two, ≥2
- MEM_LAT, 1, cycles from mem_en sample to valid mem_rdata; ≥1
- BW_LOG = log2(BLOCK_WORDS), derived localparam
- clk  in  1  clock, all state on rising edge
- rstn  in  1  reset, asynchronous, active-low
- i_req / d_req  in  1  transaction request; hold high until *_done
- i_we / d_we  in  1  1 = write burst, 0 = read burst; valid with req
- i_addr / d_addr  in  ADDR_W  any word in target block
- i_wdata / d_wdata  in  DATA_W  write data for beat given by *_beat, same cycle
- i_gnt / d_gnt  out  1  port owns memory
- i_beat / d_beat  out  BW_LOG  current beat index (write issue or read return)
- i_rvalid / d_rvalid  out  1  read word valid on *_rdata
- i_rdata / d_rdata  out  DATA_W  read data, zero when *_rvalid low
- i_done / d_done  out  1  one-cycle completion pulse
- mem_en  out  1  memory access this cycle
- mem_we  out  1  write strobe, only with mem_en
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, MEM_LAT after issue

## Operation
- States: IDLE, WR, RD, DONE, GAP.
- IDLE: sample i_req/d_req. One active → grant it. Both → grant port named by prio (reset: I); prio then flips to the other port. prio updates only on contended grants.
- On grant latch: owner, we, base = addr with low BW_LOG bits cleared. Next state WR if we else RD.
- WR: BLOCK_WORDS cycles; each cycle mem_en=1, mem_we=1, mem_addr=base+k, mem_wdata=owner wdata, owner beat=k, k=0..BLOCK_WORDS-1. After last beat → DONE.
- RD: issue BLOCK_WORDS consecutive reads (mem_en=1, mem_we=0, mem_addr=base+k), one per cycle, no stalls. MEM_LAT-deep valid shift register tracks in-flight beats; on return, owner rvalid=1, rdata=mem_rdata, beat=return index. Return counter reaches BLOCK_WORDS → DONE next cycle.
- DONE: owner done=1 one cycle, gnt still high → GAP.
- GAP: one cycle, no arbitration, all strobes low → IDLE. Lets Moore-style requesters drop req after done without re-grant.
- Non-owner outputs always 0. mem_wdata = 0 when mem_we low. mem_addr = 0 when mem_en low.
- base aligned → base+k never carries out of ADDR_W.
- req/we/addr changes after grant ignored until next IDLE. req dropped mid-burst: burst still completes.
- Reset (any state, any time): state IDLE, prio=I, counters and valid pipe cleared, all outputs 0; in-flight memory returns discarded.

## Timing
- Grant edge = edge ending IDLE cycle T where req seen.
- *_gnt high cycles T+1 .. DONE inclusive.
- Write: beats T+1..T+BLOCK_WORDS; done at T+BLOCK_WORDS+1; GAP T+BLOCK_WORDS+2; earliest next grant edge end of T+BLOCK_WORDS+3.
- Read: issue beat k at T+1+k; rvalid beat k at T+1+k+MEM_LAT; done at T+BLOCK_WORDS+MEM_LAT+1.
- Read latency to first word 1+MEM_LAT cycles after grant edge; throughput one word/cycle.
- All outputs from registers or state decode plus mem_rdata/wdata passthrough; no combinational req→gnt path.

## Test plan
- Single I read, BLOCK_WORDS=4, MEM_LAT=1, i_addr=0x13, memory word n = n*0x11 → mem_addr 0x10..0x13 cycles T+1..T+4; i_rvalid T+2..T+5 with rdata 0x110,0x121,0x132,0x143, beat 0..3; i_done T+6; d_* all 0.
- Single D write, d_addr=0x20, wdata=0xA0+beat → mem writes 0x20..0x23 with 0xA0..0xA3 T+1..T+4, d_done T+5, mem_en low T+5..T+6.
- Both req in same IDLE cycle after reset → I granted first; D granted at first IDLE after I's GAP; repeat tie → D first (prio alternates).
- Moore requester holds req one cycle past done → no second grant (GAP); req still high in IDLE → regranted.
- MEM_LAT=3 read → rvalid beats at T+4..T+7, done T+8, beats in order.
- rstn low mid-RD (after 2 returns) → all outputs 0 immediately; after release, D tie-request with I gets I first; no stale rvalid.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter that sequences fixed-length block bursts
// from the instruction and data refill paths onto one pipelined memory port.
module mem_arbiter #(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned BLOCK_WORDS = 4,
  parameter int unsigned MEM_LAT     = 1,
  localparam int unsigned BW_LOG     = $clog2(BLOCK_WORDS)
) (
  input  logic              clk,
  input  logic              rstn,

  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              i_gnt,
  output logic [BW_LOG-1:0] i_beat,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic [BW_LOG-1:0] d_beat,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = BW_LOG + 1;
  localparam logic [BW_LOG-1:0] LAST_BEAT = BW_LOG'(BLOCK_WORDS - 1);
  localparam logic [ADDR_W-1:0] BLK_MASK  = ~ADDR_W'(BLOCK_WORDS - 1);

  typedef enum logic [2:0] {IDLE, WR, RD, DONE, GAP} state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;   // 0 = port I, 1 = port D
  logic                prio_q, prio_d;     // port favoured on the next tie
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [CNT_W-1:0]    icnt_q, icnt_d;     // issue counter; MSB set once all beats issued
  logic [BW_LOG-1:0]   rcnt_q, rcnt_d;     // read return counter
  logic [MEM_LAT-1:0]  pipe_q, pipe_d;     // in-flight read tracker

  logic                sel;
  logic                wr_beat;
  logic                rd_issue;
  logic                ret;
  logic                busy;
  logic [BW_LOG-1:0]   beat;
  logic [DATA_W-1:0]   wdata_sel;

  assign ret = pipe_q[MEM_LAT-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
      base_q  <= '0;
      icnt_q  <= '0;
      rcnt_q  <= '0;
      pipe_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      base_q  <= base_d;
      icnt_q  <= icnt_d;
      rcnt_q  <= rcnt_d;
      pipe_q  <= pipe_d;
    end
  end

  // Arbitration, burst sequencing and read-return tracking
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    prio_d   = prio_q;
    base_d   = base_q;
    icnt_d   = icnt_q;
    rcnt_d   = rcnt_q;
    sel      = 1'b0;
    wr_beat  = 1'b0;
    rd_issue = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          sel = (i_req && d_req) ? prio_q : d_req;
          if (i_req && d_req) prio_d = ~prio_q;
          owner_d = sel;
          base_d  = (sel ? d_addr : i_addr) & BLK_MASK;
          icnt_d  = '0;
          rcnt_d  = '0;
          state_d = (sel ? d_we : i_we) ? WR : RD;
        end
      end
      WR: begin
        wr_beat = 1'b1;
        icnt_d  = icnt_q + CNT_W'(1);
        if (icnt_q[BW_LOG-1:0] == LAST_BEAT) state_d = DONE;
      end
      RD: begin
        rd_issue = ~icnt_q[BW_LOG];
        if (rd_issue) icnt_d = icnt_q + CNT_W'(1);
        if (ret) begin
          rcnt_d = rcnt_q + BW_LOG'(1);
          if (rcnt_q == LAST_BEAT) state_d = DONE;
        end
      end
      DONE:    state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    pipe_d = MEM_LAT'({pipe_q, rd_issue});
  end

  // Output decode; only the owner sees non-zero values
  assign busy      = (state_q == WR) || (state_q == RD) || (state_q == DONE);
  assign wdata_sel = owner_q ? d_wdata : i_wdata;

  assign mem_en    = wr_beat | rd_issue;
  assign mem_we    = wr_beat;
  assign mem_addr  = mem_en ? (base_q + ADDR_W'(icnt_q[BW_LOG-1:0])) : '0;
  assign mem_wdata = wr_beat ? wdata_sel : '0;

  assign beat = wr_beat ? icnt_q[BW_LOG-1:0] : (ret ? rcnt_q : '0);

  assign i_gnt    = busy & ~owner_q;
  assign d_gnt    = busy & owner_q;
  assign i_beat   = owner_q ? '0 : beat;
  assign d_beat   = owner_q ? beat : '0;
  assign i_rvalid = ret & ~owner_q;
  assign d_rvalid = ret & owner_q;
  assign i_rdata  = i_rvalid ? mem_rdata : '0;
  assign d_rdata  = d_rvalid ? mem_rdata : '0;
  assign i_done   = (state_q == DONE) & ~owner_q;
  assign d_done   = (state_q == DONE) & owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two lanes (MEM_LAT 1 and 3), each with its own requesters,
// pipelined memory and a transaction-timeline reference model.
module tb_mem_arbiter;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int BW     = 4;
  localparam int BW_LOG = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = (g == 0) ? 1 : 3;

    logic              rstn;
    logic              i_req, i_we, d_req, d_we;
    logic [ADDR_W-1:0] i_addr, d_addr;
    logic [DATA_W-1:0] i_wdata, d_wdata, i_wpat, d_wpat;
    logic              i_gnt, i_rvalid, i_done, d_gnt, d_rvalid, d_done;
    logic [BW_LOG-1:0] i_beat, d_beat;
    logic [DATA_W-1:0] i_rdata, d_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic [DATA_W-1:0] mem [512];
    logic [DATA_W-1:0] ref_mem [512];
    logic [DATA_W-1:0] rp [LAT];
    bit                fin = 1'b0;

    // reference model state
    int                cyc = 0;
    int                t0, free_at;
    logic              act, own_m, we_m, prio_m;
    logic [ADDR_W-1:0] base_m;

    // requesters produce write data from the beat index they are shown
    assign i_wdata   = i_wpat + DATA_W'(i_beat);
    assign d_wdata   = d_wpat + DATA_W'(d_beat);
    assign mem_rdata = rp[LAT-1];

    mem_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BLOCK_WORDS(BW), .MEM_LAT(LAT)
    ) u_dut (
      .clk(clk), .rstn(rstn),
      .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
      .i_gnt(i_gnt), .i_beat(i_beat), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_done(i_done),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_beat(d_beat), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_done(d_done),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
    );

    // pipelined memory; idle return slots carry junk that must never surface
    always @(posedge clk) begin : memory
      if (!rstn) begin
        for (int n = 0; n < 512; n++) mem[n] <= DATA_W'(n * 17);
      end else if (mem_en && mem_we) begin
        mem[mem_addr] <= mem_wdata;
      end
      rp[0] <= (mem_en && !mem_we) ? mem[mem_addr]
                                   : (32'hBAD0_0000 | DATA_W'($urandom_range(0, 65535)));
      for (int k = 1; k < LAT; k++) rp[k] <= rp[k-1];
    end

    // timeline model: a grant at cycle T fixes every output of the burst
    always @(negedge clk) begin : model
      logic [1:0]        e_gnt, e_done, e_rv;
      logic [BW_LOG-1:0] e_beat [2];
      logic [DATA_W-1:0] e_rdata [2];
      logic              e_en, e_we, both;
      logic [ADDR_W-1:0] e_addr;
      logic [DATA_W-1:0] e_wdata;
      int                rel, done_rel, k;
      e_gnt = '0; e_done = '0; e_rv = '0;
      e_beat[0] = '0; e_beat[1] = '0; e_rdata[0] = '0; e_rdata[1] = '0;
      e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
      if (!rstn) begin
        act = 1'b0; prio_m = 1'b0; free_at = 0;
        for (int n = 0; n < 512; n++) ref_mem[n] = DATA_W'(n * 17);
      end else if (act) begin
        rel      = cyc - t0;
        done_rel = we_m ? BW + 1 : BW + LAT + 1;
        if (rel >= 1 && rel <= done_rel) e_gnt[own_m] = 1'b1;
        if (rel == done_rel) e_done[own_m] = 1'b1;
        if (rel >= 1 && rel <= BW) begin
          k = rel - 1;
          e_en = 1'b1;
          e_addr = ADDR_W'(int'(base_m) + k);
          if (we_m) begin
            e_we = 1'b1;
            e_beat[own_m] = BW_LOG'(k);
            e_wdata = (own_m ? d_wpat : i_wpat) + DATA_W'(k);
            ref_mem[e_addr] = e_wdata;
          end
        end
        if (!we_m && rel >= 1 + LAT && rel <= BW + LAT) begin
          k = rel - 1 - LAT;
          e_rv[own_m] = 1'b1;
          e_beat[own_m] = BW_LOG'(k);
          e_rdata[own_m] = ref_mem[ADDR_W'(int'(base_m) + k)];
        end
      end
      chk($sformatf("L%0d c%0d port_i", g, cyc),
          128'({i_gnt, i_done, i_rvalid, i_beat, i_rdata}),
          128'({e_gnt[0], e_done[0], e_rv[0], e_beat[0], e_rdata[0]}));
      chk($sformatf("L%0d c%0d port_d", g, cyc),
          128'({d_gnt, d_done, d_rvalid, d_beat, d_rdata}),
          128'({e_gnt[1], e_done[1], e_rv[1], e_beat[1], e_rdata[1]}));
      chk($sformatf("L%0d c%0d mem", g, cyc),
          128'({mem_en, mem_we, mem_addr, mem_wdata}),
          128'({e_en, e_we, e_addr, e_wdata}));
      if (rstn && cyc >= free_at && (i_req || d_req)) begin
        both   = i_req && d_req;
        own_m  = both ? prio_m : d_req;
        if (both) prio_m = ~prio_m;
        we_m   = own_m ? d_we : i_we;
        base_m = ADDR_W'((int'(own_m ? d_addr : i_addr) / BW) * BW);
        act    = 1'b1;
        t0     = cyc;
        free_at = cyc + (we_m ? BW : BW + LAT) + 3;
      end
      cyc++;
    end

    task automatic drive(input int p, input logic rq, input logic w,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wp);
      if (p == 0) begin i_req = rq; i_we = w; i_addr = a; i_wpat = wp; end
      else        begin d_req = rq; d_we = w; d_addr = a; d_wpat = wp; end
    endtask

    function automatic logic port_done(input int p);
      return (p == 0) ? i_done : d_done;
    endfunction

    function automatic logic port_gnt(input int p);
      return (p == 0) ? i_gnt : d_gnt;
    endfunction

    // hold req through ntx completions, then keep it 'hold' extra cycles
    task automatic run_port(input int p, input logic w, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] wp, input int ntx, input int hold);
      bit seen, scr;
      @(posedge clk); #1;
      drive(p, 1'b1, w, a, wp);
      for (int n = 0; n < ntx; n++) begin
        seen = 1'b0;
        for (int t = 0; t < 200 && !seen; t++) begin
          @(negedge clk);
          seen = port_done(p);
          scr  = !seen && port_gnt(p) && ($urandom_range(0, 3) == 0);
          @(posedge clk); #1;
          if (scr) drive(p, 1'b1, 1'($urandom), ADDR_W'($urandom), wp);
        end
        if (!seen) chk($sformatf("L%0d p%0d done_timeout", g, p), 128'(0), 128'(1));
      end
      repeat (hold) begin @(posedge clk); #1; end
      drive(p, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic rand_port(input int p);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      run_port(p, 1'($urandom), ADDR_W'($urandom), $urandom,
               ($urandom_range(0, 4) == 0) ? 2 : 1, $urandom_range(0, 1));
    endtask

    initial begin : seq
      int mode, cnt;
      rstn = 1'b0;
      drive(0, 1'b0, 1'b0, '0, '0);
      drive(1, 1'b0, 1'b0, '0, '0);
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;

      run_port(0, 1'b0, 9'h013, 32'h0, 1, 0);
      repeat (3) @(posedge clk);
      run_port(1, 1'b1, 9'h020, 32'hA0, 1, 0);
      repeat (3) @(posedge clk);

      // two back-to-back ties: priority must alternate
      repeat (2) begin
        fork
          run_port(0, 1'b0, 9'h0A5, 32'h0, 1, 0);
          run_port(1, 1'b1, 9'h10C, 32'h700, 1, 0);
        join
        repeat (3) @(posedge clk);
      end

      // req held into GAP only, then held into IDLE for a regrant
      run_port(0, 1'b1, 9'h040, 32'h500, 1, 1);
      repeat (3) @(posedge clk);
      run_port(1, 1'b0, 9'h044, 32'h0, 2, 0);
      repeat (3) @(posedge clk);

      for (int n = 0; n < 30; n++) begin
        mode = $urandom_range(0, 2);
        fork
          if (mode != 1) rand_port(0);
          if (mode != 0) rand_port(1);
        join
        repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      // reset in the middle of a read after two returns
      repeat (3) @(posedge clk);
      #1 drive(0, 1'b1, 1'b0, 9'h031, 32'h0);
      cnt = 0;
      for (int t = 0; t < 50 && cnt < 2; t++) begin
        @(negedge clk);
        if (i_rvalid) cnt++;
      end
      if (cnt < 2) chk($sformatf("L%0d rd_timeout", g), 128'(0), 128'(1));
      #1 rstn = 1'b0;
      #1 chk($sformatf("L%0d rst_immediate", g),
             128'({i_gnt, i_rvalid, i_beat, i_rdata, mem_en, mem_addr, d_gnt}), 128'(0));
      drive(0, 1'b0, 1'b0, '0, '0);
      @(posedge clk);
      @(posedge clk);
      #1 rstn = 1'b1;
      fork
        run_port(0, 1'b0, 9'h1F7, 32'h0, 1, 0);
        run_port(1, 1'b0, 9'h0E2, 32'h0, 1, 0);
      join
      repeat (12) @(posedge clk);
      fin = 1'b1;
    end
  end

  initial begin : finish_up
    for (int t = 0; t < 20000 && !(lane[0].fin && lane[1].fin); t++) @(posedge clk);
    if (!(lane[0].fin && lane[1].fin)) chk("global_timeout", 128'(0), 128'(1));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
